// File: rtl/if_fetch.sv
// Instruction fetch stage: issues one outstanding word read per PC and queues
// the returned {pc, instruction} pairs for decode behind a valid/ready handshake.
module if_fetch #(
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [31:0]            in_pc,
   output logic                   pc_advance,
   input  logic                   flush,
   output logic                   imem_req,
   output logic [31:0]            imem_addr,
   input  logic                   imem_gnt,
   input  logic                   imem_rvalid,
   input  logic [31:0]            imem_rdata,
   output logic                   instr_valid,
   input  logic                   instr_ready,
   output logic [31:0]            instr_out,
   output logic [31:0]            instr_pc,
   output logic [$clog2(DEPTH):0] occupancy
);

   localparam int AW = $clog2(DEPTH);
   localparam int OW = AW + 1;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

   state_t        r_state;
   logic [31:0]   r_req_pc;
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [OW-1:0] r_occ;
   logic [31:0]   r_q_pc  [DEPTH];
   logic [31:0]   r_q_ins [DEPTH];

   logic          w_push;
   logic          w_pop;
   logic          w_room;
   logic [OW-1:0] w_occ_next;

   assign imem_req    = (r_state == REQ);
   assign imem_addr   = {r_req_pc[31:2], 2'b00};
   assign pc_advance  = imem_req && imem_gnt && !flush;
   assign instr_valid = (r_occ != '0);
   assign instr_out   = r_q_ins[r_rd_ptr];
   assign instr_pc    = r_q_pc[r_rd_ptr];
   assign occupancy   = r_occ;

   // Flush overrides any same-cycle push or pop.
   assign w_push     = (r_state == WAIT) && imem_rvalid && !flush;
   assign w_pop      = instr_valid && instr_ready && !flush;
   assign w_occ_next = r_occ + OW'(w_push) - OW'(w_pop);
   assign w_room     = (w_occ_next < OW'(DEPTH));

   // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= IDLE;
         r_req_pc <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (!flush && (r_occ < OW'(DEPTH))) begin
                  r_state  <= REQ;
                  r_req_pc <= in_pc;
               end
            end
            REQ: begin
               if (imem_gnt) r_state <= flush ? DROP : WAIT;
               else if (flush) r_state <= IDLE;
            end
            WAIT: begin
               if (imem_rvalid) begin
                  if (!flush && w_room) begin
                     r_state  <= REQ;
                     r_req_pc <= in_pc;
                  end else begin
                     r_state <= IDLE;
                  end
               end else if (flush) begin
                  r_state <= DROP;
               end
            end
            DROP: begin
               if (imem_rvalid) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // NOTE: queue storage is reset so the head outputs read 0 out of reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_q_pc[i]  <= '0;
            r_q_ins[i] <= '0;
         end
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
      end else begin
         if (w_push) begin
            r_q_pc[r_wr_ptr]  <= r_req_pc;
            r_q_ins[r_wr_ptr] <= imem_rdata;
            r_wr_ptr          <= r_wr_ptr + AW'(1);
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
         r_occ <= w_occ_next;
      end
   end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: a transaction-level queue model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_if_fetch;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] in_pc = '0;
   logic        flush = 1'b0;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        instr_ready = 1'b0;

   logic                   pc_advance;
   logic                   imem_req;
   logic [31:0]            imem_addr;
   logic                   instr_valid;
   logic [31:0]            instr_out;
   logic [31:0]            instr_pc;
   logic [$clog2(DEPTH):0] occupancy;

   always #5 clk = ~clk;

   if_fetch #(.DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_pc       (in_pc),
      .pc_advance  (pc_advance),
      .flush       (flush),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr_out   (instr_out),
      .instr_pc    (instr_pc),
      .occupancy   (occupancy)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Memory responder knobs and state
   int          gnt_delay  = 1000;
   int          rv_lat     = 1;
   int          req_cnt    = 0;
   int          rv_cnt     = 0;
   logic        fixed_en   = 1'b0;
   logic [31:0] fixed_data = 32'hDEAD_BEEF;
   logic [31:0] pend_data  = '0;

   // Reference model: a pending request, an in-flight read that is kept or
   // discarded, and a plain queue of {pc, instr}.
   logic [63:0] m_q [$];
   logic        m_asking   = 1'b0;
   logic        m_inflight = 1'b0;
   logic        m_keep     = 1'b0;
   logic [31:0] m_ask_pc   = '0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_q.delete();
         m_asking   = 1'b0;
         m_inflight = 1'b0;
         m_keep     = 1'b0;
      end else begin : upd
         int   size_before;
         logic pop_m;
         logic push_m;
         size_before = m_q.size();
         pop_m  = (size_before > 0) && instr_ready && !flush;
         push_m = m_inflight && m_keep && imem_rvalid && !flush;
         if (flush) m_q.delete();
         else begin
            if (pop_m) void'(m_q.pop_front());
            if (push_m) m_q.push_back({m_ask_pc, imem_rdata});
         end
         if (m_asking) begin
            if (imem_gnt) begin
               m_asking   = 1'b0;
               m_inflight = 1'b1;
               m_keep     = !flush;
            end else if (flush) begin
               m_asking = 1'b0;
            end
         end else if (m_inflight) begin
            if (imem_rvalid) begin
               m_inflight = 1'b0;
               if (m_keep && !flush && (m_q.size() < DEPTH)) begin
                  m_asking = 1'b1;
                  m_ask_pc = in_pc;
               end
            end else if (flush) begin
               m_keep = 1'b0;
            end
         end else if (!flush && (size_before < DEPTH)) begin
            m_asking = 1'b1;
            m_ask_pc = in_pc;
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic compare_model();
      logic [63:0] head;
      check("imem_req", imem_req, m_asking);
      if (m_asking) check("imem_addr", imem_addr, {m_ask_pc[31:2], 2'b00});
      check("pc_advance", pc_advance, m_asking && imem_gnt && !flush);
      check("instr_valid", instr_valid, m_q.size() != 0);
      check("occupancy", occupancy, m_q.size());
      if (m_q.size() != 0) begin
         head = m_q[0];
         check("instr_pc", instr_pc, head[63:32]);
         check("instr_out", instr_out, head[31:0]);
      end
   endtask

   task automatic to_neg();
      @(negedge clk);
      compare_model();
   endtask

   // Rising edge: sample DUT handshakes, then drive memory and PC inputs 1 time unit later.
   task automatic to_pos();
      logic        s_req;
      logic        s_gnt;
      logic        s_adv;
      logic [31:0] s_addr;
      @(posedge clk);
      s_req  = imem_req;
      s_gnt  = imem_gnt;
      s_adv  = pc_advance;
      s_addr = imem_addr;
      if (!rst) begin
         req_cnt = 0;
         rv_cnt  = 0;
      end else if (s_req && s_gnt) begin
         rv_cnt    = rv_lat;
         pend_data = fixed_en ? fixed_data : (32'hA000_0000 | s_addr);
         req_cnt   = 0;
      end else begin
         if (rv_cnt > 0) rv_cnt--;
         req_cnt = s_req ? req_cnt + 1 : 0;
      end
      #1;
      if (rst && s_adv) in_pc = in_pc + 32'd4;
      imem_rvalid = rst && (rv_cnt == 1);
      imem_rdata  = imem_rvalid ? pend_data : 32'h0;
      imem_gnt    = rst && imem_req && (req_cnt >= gnt_delay);
   endtask

   task automatic step();
      to_neg();
      to_pos();
   endtask

   task automatic start_from_reset(input logic [31:0] pc);
      rst = 1'b0;
      in_pc = pc;
      flush = 1'b0;
      step();
      rst = 1'b1;
   endtask

   logic        s_req_a [8];
   logic        s_adv_a [8];
   logic        s_val_a [8];
   logic [31:0] s_pc_a  [8];
   logic [31:0] s_out_a [8];
   int          adv_cnt;
   logic        found;
   logic [31:0] got_addr;

   initial begin
      // Reset held 3 cycles with in_pc = 0x100
      in_pc = 32'h100;
      step();
      step();
      to_neg();
      check("rst_imem_req", imem_req, 1'b0);
      check("rst_pc_advance", pc_advance, 1'b0);
      check("rst_instr_valid", instr_valid, 1'b0);
      check("rst_imem_addr", imem_addr, 32'h0);
      check("rst_instr_out", instr_out, 32'h0);
      check("rst_instr_pc", instr_pc, 32'h0);
      check("rst_occupancy", occupancy, 0);
      to_pos();
      rst = 1'b1;
      to_neg();
      check("rel_idle_req", imem_req, 1'b0);
      to_pos();
      to_neg();
      check("rel_req", imem_req, 1'b1);
      check("rel_addr", imem_addr, 32'h100);
      to_pos();

      // Streaming with a zero-wait memory
      gnt_delay   = 0;
      rv_lat      = 1;
      instr_ready = 1'b1;
      start_from_reset(32'h0);
      for (int c = 0; c < 8; c++) begin
         to_neg();
         s_req_a[c] = imem_req;
         s_adv_a[c] = pc_advance;
         s_val_a[c] = instr_valid;
         s_pc_a[c]  = instr_pc;
         s_out_a[c] = instr_out;
         to_pos();
      end
      adv_cnt = 0;
      for (int c = 0; c < 8; c++) adv_cnt += int'(s_adv_a[c]);
      check("stream_req_c1", s_req_a[1], 1'b1);
      check("stream_adv_c1", s_adv_a[1], 1'b1);
      check("stream_valid_c3", s_val_a[3], 1'b1);
      check("stream_pc_c3", s_pc_a[3], 32'h0);
      check("stream_out_c3", s_out_a[3], 32'hA000_0000);
      check("stream_valid_c4", s_val_a[4], 1'b0);
      check("stream_pc_c5", s_pc_a[5], 32'h4);
      check("stream_out_c5", s_out_a[5], 32'hA000_0004);
      check("stream_pc_c7", s_pc_a[7], 32'h8);
      check("stream_adv_count", adv_cnt, 4);

      // Backpressure: queue fills to DEPTH and fetching stops
      instr_ready = 1'b0;
      repeat (6) step();
      to_neg();
      check("bp_occupancy", occupancy, 2);
      check("bp_imem_req", imem_req, 1'b0);
      check("bp_pc_advance", pc_advance, 1'b0);
      check("bp_head_pc", instr_pc, 32'hC);
      check("bp_head_out", instr_out, 32'hA000_000C);
      to_pos();
      instr_ready = 1'b1;
      step();
      to_neg();
      check("bp_drain_pc", instr_pc, 32'h10);
      found    = 1'b0;
      got_addr = '0;
      for (int k = 0; k < 6 && !found; k++) begin
         to_pos();
         to_neg();
         if (imem_req) begin
            found    = 1'b1;
            got_addr = imem_addr;
         end
      end
      check("bp_resume_found", found, 1'b1);
      check("bp_resume_addr", got_addr, 32'h14);
      to_pos();

      // Flush while waiting for read data
      rv_lat   = 3;
      fixed_en = 1'b1;
      start_from_reset(32'h20);
      step();
      to_neg();
      check("fw_req_addr", imem_addr, 32'h20);
      check("fw_adv", pc_advance, 1'b1);
      to_pos();
      flush    = 1'b1;
      in_pc    = 32'h400;
      fixed_en = 1'b0;
      step();
      flush = 1'b0;
      step();
      to_neg();
      check("fw_late_rdata_occ", occupancy, 0);
      check("fw_late_rdata_valid", instr_valid, 1'b0);
      to_pos();
      to_neg();
      check("fw_after_occ", occupancy, 0);
      check("fw_after_req", imem_req, 1'b0);
      to_pos();
      to_neg();
      check("fw_new_req", imem_req, 1'b1);
      check("fw_new_addr", imem_addr, 32'h400);
      to_pos();
      repeat (6) step();

      // Flush in REQ without grant (queue non-empty), then grant+flush together
      rv_lat      = 1;
      gnt_delay   = 0;
      instr_ready = 1'b0;
      start_from_reset(32'h40);
      step();
      to_pos();
      gnt_delay = 1000;
      step();
      step();
      flush = 1'b1;
      to_neg();
      check("fr_req", imem_req, 1'b1);
      check("fr_occ", occupancy, 1);
      check("fr_head_pc", instr_pc, 32'h40);
      check("fr_head_out", instr_out, 32'hA000_0040);
      to_pos();
      flush     = 1'b0;
      gnt_delay = 0;
      to_neg();
      check("fr_withdrawn", imem_req, 1'b0);
      check("fr_emptied_occ", occupancy, 0);
      check("fr_emptied_valid", instr_valid, 1'b0);
      to_pos();
      flush = 1'b1;
      to_neg();
      check("gf_req", imem_req, 1'b1);
      check("gf_no_adv", pc_advance, 1'b0);
      to_pos();
      flush = 1'b0;
      to_neg();
      check("gf_drop_valid", instr_valid, 1'b0);
      to_pos();
      to_neg();
      check("gf_idle_req", imem_req, 1'b0);
      check("gf_idle_occ", occupancy, 0);
      to_pos();
      to_neg();
      check("gf_refetch_addr", imem_addr, 32'h44);
      to_pos();
      instr_ready = 1'b1;
      repeat (4) step();

      // Wait states on grant and data, unaligned PC bits carried through
      gnt_delay   = 3;
      rv_lat      = 4;
      instr_ready = 1'b0;
      start_from_reset(32'h83);
      adv_cnt = 0;
      for (int c = 0; c < 10; c++) begin
         to_neg();
         adv_cnt += int'(pc_advance);
         if (c >= 1 && c <= 4) begin
            check("ws_req_held", imem_req, 1'b1);
            check("ws_addr_held", imem_addr, 32'h80);
         end
         if (c == 9) begin
            check("ws_valid", instr_valid, 1'b1);
            check("ws_pc", instr_pc, 32'h83);
            check("ws_out", instr_out, 32'hA000_0080);
            check("ws_adv_count", adv_cnt, 1);
         end
         to_pos();
      end
      repeat (3) step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
